// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: channel state encoding
// and the default timing constants.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_ARM_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_ARM_L = 2'd3
    } deb_state_t;

    localparam int CLK_HZ           = 10_000_000;
    localparam int DEB_TICK_DIV     = CLK_HZ / 1000;
    localparam int DEB_STABLE_TICKS = 5;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: two-flop synchroniser, acceptance FSM and stable
// counter, advanced by the shared sample tick.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_LOW   | accepted level 0, input quiet
//   ST_ARM_H | input went high, counting ticks before accepting 1
//   ST_HIGH  | accepted level 1, input quiet
//   ST_ARM_L | input went low, counting ticks before accepting 0
module debounce_chan
    import button_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]      sync_ff;
    logic            sync;
    deb_state_t      state;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

    assign sync = sync_ff[1];

    // level/press/rel are registered alongside the state so the strobes
    // coincide exactly with the accepted level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (sync) begin
                        state <= ST_ARM_H;
                        cnt   <= '0;
                    end
                end
                ST_ARM_H: begin
                    if (!sync) begin
                        state <= ST_LOW;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_HIGH;
                            level <= 1'b1;
                            press <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_HIGH: begin
                    if (!sync) begin
                        state <= ST_ARM_L;
                        cnt   <= '0;
                    end
                end
                ST_ARM_L: begin
                    if (sync) begin
                        state <= ST_HIGH;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_LOW;
                            level <= 1'b0;
                            rel   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOW;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer top: free-running sample prescaler shared by
// N_BTN independent debounce channels.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = DEB_TICK_DIV,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == PRESC_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: expected strobes are queued with an
// acceptance window when stimulus is driven and matched as the DUT emits them.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b1111;
    logic [3:0] btn_level, btn_press, btn_release;

    logic [3:0] raw_f = 4'b0000;
    logic [3:0] level_f, press_f, release_f;

    int    total = 0;
    int    bad   = 0;
    longint cyc  = 0;

    typedef struct {
        int     ch;
        bit     is_press;
        longint lo;
        longint hi;
    } exp_t;

    exp_t   sb_q[$];
    longint press_cyc[4];
    logic [3:0] prev_level = 4'b0000;

    button_debounce #(.N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    button_debounce #(.N_BTN(4), .TICK_DIV(1), .STABLE_TICKS(1)) dut_fast (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (raw_f),
        .btn_level   (level_f),
        .btn_press   (press_f),
        .btn_release (release_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Acceptance lands 11..15 cycles after a raw edge driven just after a clock edge.
    task automatic expect_ev(input int ch, input bit is_press);
        exp_t e;
        e.ch = ch;
        e.is_press = is_press;
        e.lo = cyc + 11;
        e.hi = cyc + 15;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        int idx;
        if (rst) begin
            prev_level = 4'b0000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (btn_press[c] || btn_release[c]) begin
                    chk_val("press_rel_excl", longint'(btn_press[c] & btn_release[c]), 0);
                    idx = -1;
                    for (int k = 0; k < sb_q.size(); k++) begin
                        if (idx < 0 && sb_q[k].ch == c) idx = k;
                    end
                    if (idx < 0) begin
                        chk_val($sformatf("spurious_strobe_ch%0d", c),
                                longint'({btn_press[c], btn_release[c]}), 0);
                    end else begin
                        chk_val($sformatf("strobe_kind_ch%0d", c),
                                longint'(btn_press[c]), longint'(sb_q[idx].is_press));
                        chk_val($sformatf("strobe_window_ch%0d", c),
                                longint'(cyc >= sb_q[idx].lo && cyc <= sb_q[idx].hi), 1);
                        chk_val($sformatf("level_at_strobe_ch%0d", c),
                                longint'(btn_level[c]), longint'(btn_press[c]));
                        chk_val($sformatf("level_before_strobe_ch%0d", c),
                                longint'(prev_level[c]), longint'(btn_release[c]));
                        if (btn_press[c]) press_cyc[c] = cyc;
                        sb_q.delete(idx);
                    end
                end else if (btn_level[c] !== prev_level[c]) begin
                    chk_val($sformatf("level_no_strobe_ch%0d", c),
                            longint'(btn_level[c]), longint'(prev_level[c]));
                end
            end
            prev_level = btn_level;
        end
    end

    initial begin
        int np, nr, nx;
        longint t0, first;

        for (int c = 0; c < 4; c++) press_cyc[c] = -1;

        // reset held with all inputs high
        step(5);
        @(negedge clk);
        chk_val("rst_level",   longint'(btn_level),   0);
        chk_val("rst_press",   longint'(btn_press),   0);
        chk_val("rst_release", longint'(btn_release), 0);
        step(1);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) expect_ev(c, 1'b1);
        step(20);
        chk_val("level_after_rst", longint'(btn_level), 4'hF);

        btn_raw = 4'b0000;
        for (int c = 0; c < 4; c++) expect_ev(c, 1'b0);
        step(20);
        chk_val("level_all_low", longint'(btn_level), 0);

        // bounce on ch0 never long enough to be accepted
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_raw[0] = ~btn_raw[0];
            step(1);
        end
        btn_raw[0] = 1'b0;
        step(20);
        chk_val("bounce_level_ch0", longint'(btn_level[0]), 0);

        // clean press / hold / release on ch1
        btn_raw[1] = 1'b1;
        expect_ev(1, 1'b1);
        step(30);
        chk_val("hold_level_ch1", longint'(btn_level[1]), 1);
        btn_raw[1] = 1'b0;
        expect_ev(1, 1'b0);
        step(20);
        chk_val("release_level_ch1", longint'(btn_level[1]), 0);

        // simultaneous press on ch2 and ch3
        btn_raw[3:2] = 2'b11;
        expect_ev(2, 1'b1);
        expect_ev(3, 1'b1);
        step(20);
        chk_val("simul_level", longint'(btn_level), 4'b1100);
        chk_val("simul_same_cycle", press_cyc[3], press_cyc[2]);
        btn_raw[3:2] = 2'b00;
        expect_ev(2, 1'b0);
        expect_ev(3, 1'b0);
        step(20);

        // reset in the middle of arming ch0
        btn_raw[0] = 1'b1;
        step(6);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        expect_ev(0, 1'b1);
        step(20);
        chk_val("midrst_level_ch0", longint'(btn_level[0]), 1);
        btn_raw[0] = 1'b0;
        expect_ev(0, 1'b0);
        step(20);

        chk_val("sb_empty", longint'(sb_q.size()), 0);

        // minimum legal settings: tick every cycle, one stable tick
        raw_f = 4'b0001;
        t0 = cyc;
        np = 0; nx = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            np += int'(press_f[0]);
            nx += int'(press_f[3:1] != 0) + int'(release_f != 0);
            if (level_f[0] && first < 0) first = cyc - t0;
        end
        chk_val("fast_press_count", np, 1);
        chk_val("fast_press_latency", longint'(first >= 3 && first <= 4), 1);
        chk_val("fast_xtalk", nx, 0);
        step(1);
        raw_f = 4'b0000;
        t0 = cyc;
        nr = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nr += int'(release_f[0]);
            if (!level_f[0] && first < 0) first = cyc - t0;
        end
        chk_val("fast_release_count", nr, 1);
        chk_val("fast_release_latency", longint'(first >= 3 && first <= 4), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
